// File: rtl/mips_core_pkg.sv
// Shared front-end definitions: profiling counter layout and index-width helpers
// for the hazard stage controller.
package mips_core_pkg;

  // Counter bank layout: per-stage stall counters, then per-source redirect
  // counters, then the total-cycle counter.
  typedef enum logic [1:0] {
    STALL_BASE,
    REDIR_BASE,
    TOTAL_IDX
  } hazard_cnt_e;

  function automatic int sw_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_base(input hazard_cnt_e kind, input int n_stages,
                                  input int n_redirect);
    case (kind)
      STALL_BASE: return 0;
      REDIR_BASE: return n_stages;
      default:    return n_stages + n_redirect;
    endcase
  endfunction

  function automatic int clamp_stage(input int stage, input int n_stages);
    return (stage >= n_stages) ? n_stages - 1 : stage;
  endfunction

endpackage

// File: rtl/hazard_stage_controller_if.sv
// Pipeline-facing bundle of the hazard stage controller: hazards and redirect
// requests in, per-register stall/flush and the PC load out.
interface hazard_stage_controller_if
  import mips_core_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int NUM_REDIRECT = 2,
  parameter int ADDR_WIDTH   = 32
);
  localparam int SW = sw_width(NUM_STAGES);

  logic [NUM_STAGES-1:0]            stage_hazard;
  logic [NUM_REDIRECT-1:0]          redirect_valid;
  logic [NUM_REDIRECT*SW-1:0]       redirect_stage;
  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redirect_pc;
  logic [NUM_REDIRECT-1:0]          redirect_ready;
  logic [NUM_STAGES-1:0]            stall;
  logic [NUM_STAGES-1:0]            flush;
  logic                             load_pc_we;
  logic [ADDR_WIDTH-1:0]            load_pc_new;

  modport master (
    output stage_hazard, redirect_valid, redirect_stage, redirect_pc,
    input  redirect_ready, stall, flush, load_pc_we, load_pc_new
  );

  modport slave (
    input  stage_hazard, redirect_valid, redirect_stage, redirect_pc,
    output redirect_ready, stall, flush, load_pc_we, load_pc_new
  );
endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating profiling counter with synchronous clear that overrides increment.
module hazard_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] value
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stage_controller.sv
// N-stage hazard controller: resolves stage stalls and ranked redirects into
// per-register stall/flush and the PC load, with profiling counters and a watchdog.
module hazard_stage_controller
  import mips_core_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int NUM_REDIRECT = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int WATCHDOG     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stage_controller_if.slave pipe,
  input  logic [$clog2(NUM_STAGES+NUM_REDIRECT+1)-1:0] cnt_sel,
  output logic [CNT_WIDTH-1:0] cnt_value,
  input  logic                 cnt_clear,
  output logic                 deadlock
);

  localparam int SW        = sw_width(NUM_STAGES);
  localparam int NUM_CNT   = NUM_STAGES + NUM_REDIRECT + 1;
  localparam int REDIR_OFS = cnt_base(REDIR_BASE, NUM_STAGES, NUM_REDIRECT);
  localparam int TOTAL_OFS = cnt_base(TOTAL_IDX, NUM_STAGES, NUM_REDIRECT);

  logic                    hz_any;
  logic [SW-1:0]           hz_top;
  logic [SW-1:0]           cand_stage;
  logic                    win_valid;
  logic [SW-1:0]           win_stage;
  logic [NUM_REDIRECT-1:0] win_sel;
  logic [ADDR_WIDTH-1:0]   win_pc;
  logic                    accept;
  logic [NUM_STAGES-1:0]   stall_c;
  logic [NUM_STAGES-1:0]   flush_c;
  logic [NUM_REDIRECT-1:0] ready_c;
  logic                    pc_we_c;
  logic [ADDR_WIDTH-1:0]   pc_new_c;
  logic [NUM_CNT-1:0]      cnt_inc;
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_CNT];
  logic                    deadlock_q;

  always_comb begin
    // NOTE: every signal of this block gets a default first so no path can infer a latch.
    hz_any     = 1'b0;
    hz_top     = '0;
    cand_stage = '0;
    win_valid  = 1'b0;
    win_stage  = '0;
    win_sel    = '0;
    win_pc     = '0;
    accept     = 1'b0;
    stall_c    = '0;
    flush_c    = '0;
    ready_c    = '0;
    pc_we_c    = 1'b0;
    pc_new_c   = '0;
    cnt_inc    = '0;

    // Ascending scan: the last hit is the most downstream hazard.
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (pipe.stage_hazard[i]) begin
        hz_any = 1'b1;
        hz_top = SW'(i);
      end
    end

    // Strictly-greater keeps the lower source index on a stage tie.
    for (int k = 0; k < NUM_REDIRECT; k++) begin
      cand_stage = SW'(clamp_stage(int'(pipe.redirect_stage[k*SW +: SW]), NUM_STAGES));
      if (pipe.redirect_valid[k] && (!win_valid || (cand_stage > win_stage))) begin
        win_valid  = 1'b1;
        win_stage  = cand_stage;
        win_sel    = '0;
        win_sel[k] = 1'b1;
        win_pc     = pipe.redirect_pc[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end

    // A stall downstream of the redirecting stage holds the redirecting instruction.
    accept = win_valid && (!hz_any || (hz_top <= win_stage));

    for (int i = 0; i < NUM_STAGES; i++) begin
      if (hz_any && (i <= int'(hz_top)))     stall_c[i] = 1'b1;
      if (hz_any && (i == int'(hz_top) + 1)) flush_c[i] = 1'b1;
    end

    if (accept) begin
      ready_c  = win_sel;
      pc_we_c  = 1'b1;
      pc_new_c = win_pc;
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (i <= int'(win_stage)) begin
          stall_c[i] = 1'b0;
          flush_c[i] = (i != 0);
        end
      end
    end

    for (int i = 0; i < NUM_STAGES; i++) begin
      cnt_inc[i] = hz_any && (int'(hz_top) == i) && !accept;
    end
    for (int k = 0; k < NUM_REDIRECT; k++) begin
      cnt_inc[REDIR_OFS + k] = accept && win_sel[k];
    end
    cnt_inc[TOTAL_OFS] = 1'b1;
  end

  // Outputs are forced to their reset values for as long as rst_n is low.
  assign pipe.stall          = rst_n ? stall_c  : '0;
  assign pipe.flush          = rst_n ? flush_c  : '1;
  assign pipe.redirect_ready = rst_n ? ready_c  : '0;
  assign pipe.load_pc_we     = rst_n ? pc_we_c  : 1'b0;
  assign pipe.load_pc_new    = rst_n ? pc_new_c : '0;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    hazard_sat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (cnt_inc[g]),
      .clr  (cnt_clear),
      .value(cnt_q[g])
    );
  end

  assign cnt_value = (int'(cnt_sel) < NUM_CNT) ? cnt_q[cnt_sel] : '0;

  if (WATCHDOG > 0) begin : g_wd
    localparam int WDW = $clog2(WATCHDOG + 1);
    logic [WDW-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wd_cnt     <= '0;
        deadlock_q <= 1'b0;
      end else if (cnt_clear) begin
        wd_cnt     <= '0;
        deadlock_q <= 1'b0;
      end else begin
        if (!stall_c[0]) begin
          wd_cnt <= '0;
        end else if (wd_cnt != WDW'(WATCHDOG)) begin
          wd_cnt <= wd_cnt + 1'b1;
        end
        // Flag rises on the same edge the run length reaches WATCHDOG.
        if (stall_c[0] && (wd_cnt == WDW'(WATCHDOG - 1))) begin
          deadlock_q <= 1'b1;
        end
      end
    end
  end else begin : g_no_wd
    assign deadlock_q = 1'b0;
  end

  assign deadlock = deadlock_q;

endmodule

// File: tb/tb_hazard_stage_controller.sv
// Directed bench for hazard_stage_controller: vectors push hand-computed
// expectations into a scoreboard queue that a negedge monitor drains.
module tb_hazard_stage_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] cnt_sel = '0;
  logic [2:0] cnt_value;
  logic       cnt_clear = 1'b0;
  logic       deadlock;

  always #5 clk = ~clk;

  hazard_stage_controller_if #(.NUM_STAGES(4), .NUM_REDIRECT(2), .ADDR_WIDTH(32)) pipe_if ();

  hazard_stage_controller #(
    .NUM_STAGES  (4),
    .NUM_REDIRECT(2),
    .ADDR_WIDTH  (32),
    .CNT_WIDTH   (3),
    .WATCHDOG    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pipe     (pipe_if),
    .cnt_sel  (cnt_sel),
    .cnt_value(cnt_value),
    .cnt_clear(cnt_clear),
    .deadlock (deadlock)
  );

  typedef struct {
    int          id;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic [1:0]  ready;
    logic        we;
    logic [31:0] pc;
    logic        chk_cnt;
    logic [2:0]  cnt;
    logic        dl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Redirect stimulus staged here and applied together with the next vector.
  logic [1:0]  rv_s  = '0;
  logic [1:0]  rs0_s = '0;
  logic [1:0]  rs1_s = '0;
  logic [31:0] pc0_s = '0;
  logic [31:0] pc1_s = '0;

  task automatic check(input int id, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, what, act, exp);
    end
  endtask

  task automatic set_redir(input logic [1:0] rv, input logic [1:0] rs0, input logic [31:0] pc0,
                           input logic [1:0] rs1, input logic [31:0] pc1);
    rv_s  = rv;
    rs0_s = rs0;
    pc0_s = pc0;
    rs1_s = rs1;
    pc1_s = pc1;
  endtask

  task automatic step(input int id, input logic rst, input logic [3:0] hz, input logic [2:0] sel,
                      input logic clr, input logic [3:0] e_st, input logic [3:0] e_fl,
                      input logic [1:0] e_rdy, input logic e_we, input logic [31:0] e_pc,
                      input logic chk, input logic [2:0] e_cnt, input logic e_dl);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n                  = rst;
    pipe_if.stage_hazard   = hz;
    pipe_if.redirect_valid = rv_s;
    pipe_if.redirect_stage = {rs1_s, rs0_s};
    pipe_if.redirect_pc    = {pc1_s, pc0_s};
    cnt_sel                = sel;
    cnt_clear              = clr;
    e.id      = id;
    e.stall   = e_st;
    e.flush   = e_fl;
    e.ready   = e_rdy;
    e.we      = e_we;
    e.pc      = e_pc;
    e.chk_cnt = chk;
    e.cnt     = e_cnt;
    e.dl      = e_dl;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.id, "stall", 32'(pipe_if.stall), 32'(e.stall));
        check(e.id, "flush", 32'(pipe_if.flush), 32'(e.flush));
        check(e.id, "ready", 32'(pipe_if.redirect_ready), 32'(e.ready));
        check(e.id, "load_pc_we", 32'(pipe_if.load_pc_we), 32'(e.we));
        check(e.id, "load_pc_new", pipe_if.load_pc_new, e.pc);
        check(e.id, "deadlock", 32'(deadlock), 32'(e.dl));
        if (e.chk_cnt) check(e.id, "cnt_value", 32'(cnt_value), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    pipe_if.stage_hazard   = '0;
    pipe_if.redirect_valid = '0;
    pipe_if.redirect_stage = '0;
    pipe_if.redirect_pc    = '0;
    repeat (2) @(posedge clk);

    // In reset: hazards and a redirect are present but outputs stay at reset values.
    set_redir(2'b01, 2'd3, 32'h400, 2'd0, 32'h0);
    step(0, 0, 4'b0001, 3'd6, 0, 4'b0000, 4'b1111, 2'b00, 0, 32'h0, 1, 3'd0, 0);
    set_redir(2'b00, 2'd0, 32'h0, 2'd0, 32'h0);

    // Single hazard at stage 0; counter 0 accumulates.
    step(1, 1, 4'b0001, 3'd0, 0, 4'b0001, 4'b0010, 2'b00, 0, 32'h0, 1, 3'd0, 0);
    step(2, 1, 4'b0001, 3'd0, 0, 4'b0001, 4'b0010, 2'b00, 0, 32'h0, 1, 3'd1, 0);
    step(3, 1, 4'b0001, 3'd0, 0, 4'b0001, 4'b0010, 2'b00, 0, 32'h0, 1, 3'd2, 0);
    // Stage 2 subsumes stage 0.
    step(4, 1, 4'b0101, 3'd0, 0, 4'b0111, 4'b1000, 2'b00, 0, 32'h0, 1, 3'd3, 0);
    step(5, 1, 4'b0000, 3'd2, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd1, 0);
    step(6, 1, 4'b0000, 3'd0, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd3, 0);

    // Deeper redirect wins.
    set_redir(2'b11, 2'd3, 32'h400, 2'd1, 32'h80);
    step(7, 1, 4'b0000, 3'd4, 0, 4'b0000, 4'b1110, 2'b01, 1, 32'h400, 1, 3'd0, 0);
    set_redir(2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    step(8, 1, 4'b0000, 3'd4, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd1, 0);

    // Downstream hazard blocks the redirect, then it is accepted.
    set_redir(2'b10, 2'd0, 32'h0, 2'd2, 32'h200);
    step(9, 1, 4'b1000, 3'd3, 0, 4'b1111, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd0, 0);
    step(10, 1, 4'b0000, 3'd3, 0, 4'b0000, 4'b0110, 2'b10, 1, 32'h200, 1, 3'd1, 0);
    set_redir(2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    step(11, 1, 4'b0000, 3'd5, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd1, 0);

    // Stage tie goes to source 0; upstream hazards are overridden.
    set_redir(2'b11, 2'd2, 32'h111, 2'd2, 32'h222);
    step(12, 1, 4'b0011, 3'd4, 0, 4'b0000, 4'b0110, 2'b01, 1, 32'h111, 1, 3'd1, 0);
    // Hazard exactly at the redirect stage: accepted, flush above r kept.
    set_redir(2'b01, 2'd1, 32'h44, 2'd0, 32'h0);
    step(13, 1, 4'b0010, 3'd4, 0, 4'b0000, 4'b0110, 2'b01, 1, 32'h44, 1, 3'd2, 0);
    set_redir(2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    step(14, 1, 4'b0000, 3'd1, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd0, 0);
    step(15, 1, 4'b0000, 3'd4, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd3, 0);
    step(16, 1, 4'b0000, 3'd6, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd7, 0);
    step(17, 1, 4'b0000, 3'd7, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd0, 0);

    // Stage 1 held 10 cycles: counter 1 saturates at 7, watchdog trips after 8.
    for (int i = 0; i < 10; i++) begin
      step(18 + i, 1, 4'b0010, 3'd1, 0, 4'b0011, 4'b0100, 2'b00, 0, 32'h0, 1,
           (i > 7) ? 3'd7 : 3'(i), (i >= 8));
    end
    step(28, 1, 4'b0000, 3'd1, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd7, 1);
    step(29, 1, 4'b0000, 3'd1, 1, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd7, 1);
    step(30, 1, 4'b0000, 3'd6, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd0, 0);
    step(31, 1, 4'b0000, 3'd1, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd0, 0);

    // Watchdog: exactly 8 stalled cycles, then the flag stays sticky.
    for (int i = 0; i < 8; i++) begin
      step(32 + i, 1, 4'b0001, 3'd0, 0, 4'b0001, 4'b0010, 2'b00, 0, 32'h0, 1, 3'(i), 0);
    end
    step(40, 1, 4'b0000, 3'd0, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd7, 1);
    step(41, 1, 4'b0000, 3'd0, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd7, 1);

    // Mid-run reset clears everything at once; post-reset cycle is cycle 0.
    set_redir(2'b01, 2'd3, 32'h400, 2'd0, 32'h0);
    step(42, 0, 4'b0101, 3'd6, 0, 4'b0000, 4'b1111, 2'b00, 0, 32'h0, 1, 3'd0, 0);
    set_redir(2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    step(43, 1, 4'b0000, 3'd6, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd0, 0);
    step(44, 1, 4'b0000, 3'd6, 0, 4'b0000, 4'b0000, 2'b00, 0, 32'h0, 1, 3'd1, 0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
